// File: rtl/rob_pkg.sv
// Shared widths, entry type and tag/index helpers for the reorder-buffer commit unit.
package rob_pkg;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // Entry i owns tag i+1 so that tag 0 stays free to mean "value ready".
    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
        return idx + TAG_W'(1);
    endfunction

    function automatic logic [TAG_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        return tag - TAG_W'(1);
    endfunction
endpackage

// File: rtl/rob_ptr_wrap.sv
// Circular pointer advance by 0, 1 or 2 positions modulo DEPTH.
module rob_ptr_wrap #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic [PTR_W-1:0] i_ptr,
    input  logic [1:0]       i_inc,
    output logic [PTR_W-1:0] o_ptr
);
    logic [31:0] w_sum;

    always_comb begin
        w_sum = 32'(i_ptr) + 32'(i_inc);
        if (w_sum >= DEPTH) begin
            w_sum = w_sum - DEPTH;
        end
        o_ptr = PTR_W'(w_sum);
    end
endmodule

// File: rtl/rob_commit_unit.sv
// Reorder-buffer commit unit: allocates rename tags, gathers results from two completion buses
// and retires up to two per cycle in program order. Optional counters under ROB_STATS_EN.
module rob_commit_unit #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TAG_W  = rob_pkg::TAG_W,
    parameter int unsigned DATA_W = rob_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      alloc1_req,
    input  logic [rob_pkg::REG_W-1:0] alloc1_rd,
    input  logic                      alloc2_req,
    input  logic [rob_pkg::REG_W-1:0] alloc2_rd,
    output logic                      alloc1_ready,
    output logic                      alloc2_ready,
    output logic [TAG_W-1:0]          alloc1_tag,
    output logic [TAG_W-1:0]          alloc2_tag,
    input  logic                      cmp1_valid,
    input  logic [TAG_W-1:0]          cmp1_tag,
    input  logic [DATA_W-1:0]         cmp1_data,
    input  logic                      cmp2_valid,
    input  logic [TAG_W-1:0]          cmp2_tag,
    input  logic [DATA_W-1:0]         cmp2_data,
    output logic                      write1,
    output logic [rob_pkg::REG_W-1:0] WR1,
    output logic [DATA_W-1:0]         WD1,
    output logic [TAG_W-1:0]          Writer1Tag,
    output logic                      write2,
    output logic [rob_pkg::REG_W-1:0] WR2,
    output logic [DATA_W-1:0]         WD2,
    output logic [TAG_W-1:0]          Writer2Tag,
    output logic [TAG_W-1:0]          occupancy
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]               retired_count,
    output logic [31:0]               full_cycles
`endif
);
    import rob_pkg::*;

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rob_entry_t        r_ent [DEPTH];
    logic [IDX_W-1:0]  r_head, r_tail;
    logic [TAG_W-1:0]  r_count;
    logic              r_write1, r_write2;
    logic [REG_W-1:0]  r_wr1, r_wr2;
    logic [DATA_W-1:0] r_wd1, r_wd2;
    logic [TAG_W-1:0]  r_tag1, r_tag2;

    logic              w_ready1, w_ready2, w_acc1, w_acc2, w_ret1, w_ret2;
    logic              w_cmp1_hit, w_cmp2_hit;
    logic [1:0]        w_acc_n, w_ret_n;
    logic [IDX_W-1:0]  w_head_p1, w_head_nxt, w_tail_p1, w_tail_nxt;
    logic [IDX_W-1:0]  w_cmp1_idx, w_cmp2_idx;

    always_comb begin
        w_ready1   = 32'(r_count) < DEPTH;
        w_ready2   = (32'(r_count) + 32'd2) <= DEPTH;
        w_acc1     = alloc1_req && w_ready1;
        w_acc2     = alloc2_req && w_ready2 && w_acc1;
        w_acc_n    = {1'b0, w_acc1} + {1'b0, w_acc2};
        w_cmp1_idx = IDX_W'(tag_to_idx(cmp1_tag));
        w_cmp2_idx = IDX_W'(tag_to_idx(cmp2_tag));
        // Out-of-range tags are screened before the entry's valid bit can matter.
        w_cmp1_hit = cmp1_valid && (cmp1_tag != NO_TAG) && (32'(cmp1_tag) <= DEPTH)
                     && r_ent[w_cmp1_idx].valid;
        w_cmp2_hit = cmp2_valid && (cmp2_tag != NO_TAG) && (32'(cmp2_tag) <= DEPTH)
                     && r_ent[w_cmp2_idx].valid;
        w_ret1     = r_ent[r_head].valid && r_ent[r_head].done;
        w_ret2     = w_ret1 && r_ent[w_head_p1].valid && r_ent[w_head_p1].done;
        w_ret_n    = {1'b0, w_ret1} + {1'b0, w_ret2};
    end

    rob_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(IDX_W)) u_head_p1 (
        .i_ptr(r_head), .i_inc(2'd1), .o_ptr(w_head_p1)
    );
    rob_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(IDX_W)) u_head_nxt (
        .i_ptr(r_head), .i_inc(w_ret_n), .o_ptr(w_head_nxt)
    );
    rob_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(IDX_W)) u_tail_p1 (
        .i_ptr(r_tail), .i_inc(2'd1), .o_ptr(w_tail_p1)
    );
    rob_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(IDX_W)) u_tail_nxt (
        .i_ptr(r_tail), .i_inc(w_acc_n), .o_ptr(w_tail_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent[IDX_W'(i)] <= '0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_write1 <= 1'b0;
            r_write2 <= 1'b0;
            r_wr1    <= '0;
            r_wr2    <= '0;
            r_wd1    <= '0;
            r_wd2    <= '0;
            r_tag1   <= '0;
            r_tag2   <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ent[IDX_W'(i)].valid <= 1'b0;
                r_ent[IDX_W'(i)].done  <= 1'b0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_write1 <= 1'b0;
            r_write2 <= 1'b0;
        end else begin
            // Ordering matters: bus 2 overrides bus 1, retire clears, then allocation claims.
            if (w_cmp1_hit) begin
                r_ent[w_cmp1_idx].done <= 1'b1;
                r_ent[w_cmp1_idx].data <= cmp1_data;
            end
            if (w_cmp2_hit) begin
                r_ent[w_cmp2_idx].done <= 1'b1;
                r_ent[w_cmp2_idx].data <= cmp2_data;
            end
            if (w_ret1) begin
                r_ent[r_head].valid <= 1'b0;
                r_ent[r_head].done  <= 1'b0;
            end
            if (w_ret2) begin
                r_ent[w_head_p1].valid <= 1'b0;
                r_ent[w_head_p1].done  <= 1'b0;
            end
            if (w_acc1) begin
                r_ent[r_tail].valid <= 1'b1;
                r_ent[r_tail].done  <= 1'b0;
                r_ent[r_tail].rd    <= alloc1_rd;
            end
            if (w_acc2) begin
                r_ent[w_tail_p1].valid <= 1'b1;
                r_ent[w_tail_p1].done  <= 1'b0;
                r_ent[w_tail_p1].rd    <= alloc2_rd;
            end
            r_head   <= w_head_nxt;
            r_tail   <= w_tail_nxt;
            r_count  <= r_count + TAG_W'(w_acc_n) - TAG_W'(w_ret_n);
            r_write1 <= w_ret1 && (r_ent[r_head].rd != '0);
            r_write2 <= w_ret2 && (r_ent[w_head_p1].rd != '0);
            if (w_ret1) begin
                r_wr1  <= r_ent[r_head].rd;
                r_wd1  <= r_ent[r_head].data;
                r_tag1 <= idx_to_tag(TAG_W'(r_head));
            end
            if (w_ret2) begin
                r_wr2  <= r_ent[w_head_p1].rd;
                r_wd2  <= r_ent[w_head_p1].data;
                r_tag2 <= idx_to_tag(TAG_W'(w_head_p1));
            end
        end
    end

`ifdef ROB_STATS_EN
    logic [31:0] r_retired, r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_full    <= '0;
        end else begin
            if (!flush) begin
                r_retired <= r_retired + 32'(w_ret_n);
            end
            if (32'(r_count) == DEPTH) begin
                r_full <= r_full + 32'd1;
            end
        end
    end

    assign retired_count = r_retired;
    assign full_cycles   = r_full;
`endif

    always_comb begin
        alloc1_ready = w_ready1;
        alloc2_ready = w_ready2;
        alloc1_tag   = idx_to_tag(TAG_W'(r_tail));
        alloc2_tag   = idx_to_tag(TAG_W'(w_tail_p1));
        write1       = r_write1;
        WR1          = r_wr1;
        WD1          = r_wd1;
        Writer1Tag   = r_tag1;
        write2       = r_write2;
        WR2          = r_wr2;
        WD2          = r_wd2;
        Writer2Tag   = r_tag2;
        occupancy    = r_count;
    end
endmodule
